// File: rtl/addrdecode_track.sv
// Registered address decoder with a same-slave ordering lock and a built-in bus-error responder.
// Optional build macro ADDRDECODE_LOWPOWER_EN: o_addr/o_data read as zero whenever o_valid is low.
module addrdecode_track #(
  parameter int NS        = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LGMAXPEND = 3,
  parameter logic [NS*AW-1:0] SLAVE_ADDR =
    {32'hC000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000},
  parameter logic [NS-1:0] ACCESS_ALLOWED = '1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  output logic                 o_stall,
  input  logic [AW-1:0]        i_addr,
  input  logic [DW-1:0]        i_data,
  output logic                 o_valid,
  input  logic                 i_stall,
  output logic [NS-1:0]        o_decode,
  output logic [AW-1:0]        o_addr,
  output logic [DW-1:0]        o_data,
  input  logic                 i_rsp_valid,
  output logic                 o_err,
  output logic [LGMAXPEND-1:0] o_pending,
  output logic                 o_fault
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [LGMAXPEND:0] MAXPEND = {1'b0, {LGMAXPEND{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t               state_q;
  logic [LGMAXPEND-1:0] cnt_q, cnt_d;
  logic                 fault_q, fault_d;
  logic                 err_q;
  logic [SW-1:0]        lock_q, lock_d;
  logic                 valid_q, valid_d;
  logic [NS-1:0]        decode_q, decode_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;

  logic [SW-1:0]        slave;
  logic [NS-1:0]        sel_oh;
  logic                 none;
  logic [LGMAXPEND:0]   inflight;
  logic                 issue, rsp_dec, blocked, accept;

  // Scan from the top so the lowest-index match is the one left standing.
  always_comb begin
    slave  = '0;
    sel_oh = '0;
    none   = 1'b1;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((((i_addr ^ SLAVE_ADDR[k*AW +: AW]) & SLAVE_MASK[k*AW +: AW]) == '0)
          && ACCESS_ALLOWED[k]) begin
        slave     = SW'(k);
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        none      = 1'b0;
      end
    end
  end

  assign inflight = {1'b0, cnt_q} + {{LGMAXPEND{1'b0}}, valid_q};
  assign issue    = valid_q && !i_stall;
  assign rsp_dec  = i_rsp_valid && (cnt_q != '0);

  // A full pipe may still take a request when a response frees a slot this cycle.
  always_comb begin
    blocked = 1'b0;
    if (state_q == ERR)                                  blocked = 1'b1;
    if (valid_q && i_stall)                              blocked = 1'b1;
    if ((inflight != '0) && (none || (slave != lock_q))) blocked = 1'b1;
    if ((inflight == MAXPEND) && !rsp_dec)               blocked = 1'b1;
  end

  assign o_stall = i_valid && blocked;
  assign accept  = i_valid && !blocked;

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !rsp_dec)      cnt_d = cnt_q + 1'b1;
    else if (rsp_dec && !issue) cnt_d = cnt_q - 1'b1;
    fault_d = fault_q || (i_rsp_valid && (cnt_q == '0));
  end

  always_comb begin
    valid_d  = valid_q;
    decode_d = decode_q;
    addr_d   = addr_q;
    data_d   = data_q;
    lock_d   = lock_q;
    if (accept && !none) begin
      valid_d  = 1'b1;
      decode_d = sel_oh;
      addr_d   = i_addr;
      data_d   = i_data;
      lock_d   = slave;
    end else if (issue) begin
      valid_d  = 1'b0;
      decode_d = '0;
`ifdef ADDRDECODE_LOWPOWER_EN
      addr_d   = '0;
      data_d   = '0;
`else
      addr_d   = addr_q;
      data_d   = data_q;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= '0;
      valid_q  <= 1'b0;
      decode_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      lock_q   <= lock_d;
      valid_q  <= valid_d;
      decode_q <= decode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= accept && none;
      case (state_q)
        IDLE: begin
          if (accept) state_q <= none ? ERR : ACTIVE;
        end
        ACTIVE: begin
          if (accept)                 state_q <= none ? ERR : ACTIVE;
          else if (inflight == '0)    state_q <= IDLE;
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid   = valid_q;
  assign o_decode  = decode_q;
  assign o_addr    = addr_q;
  assign o_data    = data_q;
  assign o_err     = err_q;
  assign o_pending = cnt_q;
  assign o_fault   = fault_q;

endmodule

// File: tb/tb_addrdecode_track.sv
// Scoreboard bench for addrdecode_track: NS=4, LGMAXPEND=2, four-region address map.
module tb_addrdecode_track;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_stall;
  logic [31:0] i_addr = '0;
  logic [31:0] i_data = '0;
  logic        o_valid;
  logic        i_stall = 1'b0;
  logic [3:0]  o_decode;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic        i_rsp_valid = 1'b0;
  logic        o_err;
  logic [1:0]  o_pending;
  logic        o_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          err;
    logic [3:0]  dec;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   m_pend  = 0;
  bit   m_fault = 1'b0;

  addrdecode_track #(
    .NS(4), .AW(32), .DW(32), .LGMAXPEND(2),
    .SLAVE_ADDR({32'hC000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000}),
    .ACCESS_ALLOWED(4'hF)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_stall(o_stall),
    .i_addr(i_addr), .i_data(i_data), .o_valid(o_valid), .i_stall(i_stall),
    .o_decode(o_decode), .o_addr(o_addr), .o_data(o_data),
    .i_rsp_valid(i_rsp_valid), .o_err(o_err), .o_pending(o_pending), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address map written out by region: {none, onehot}
  function automatic logic [4:0] model_dec(input logic [31:0] a);
    casez (a[31:28])
      4'b00??: return 5'b00001;
      4'b10??: return 5'b00010;
      4'b01??: return 5'b00100;
      4'b1100: return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  always @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sb.delete();
      m_pend  = 0;
      m_fault = 1'b0;
    end else begin
      exp_t e;
      logic [4:0] md;
      if (!o_valid) check("dec_idle", {60'd0, o_decode}, 64'd0);
      if (o_decode[3]) check("order", {62'd0, o_pending}, 64'd0);
      check("pending", {62'd0, o_pending}, 64'(m_pend));
      check("fault", {63'd0, o_fault}, {63'd0, m_fault});
      if (o_valid && !i_stall) begin
        if (sb.size() == 0) check("sb_underflow", 64'd0, 64'd1);
        else begin
          e = sb.pop_front();
          check("issue_kind", {63'd0, e.err}, 64'd0);
          check("issue_dec", {60'd0, o_decode}, {60'd0, e.dec});
          check("issue_addr", {32'd0, o_addr}, {32'd0, e.addr});
          check("issue_data", {32'd0, o_data}, {32'd0, e.data});
        end
      end
      if (o_err) begin
        if (sb.size() == 0) check("sb_underflow_err", 64'd0, 64'd1);
        else begin
          e = sb.pop_front();
          check("err_kind", {63'd0, e.err}, 64'd1);
        end
      end
      if (i_valid && !o_stall) begin
        md     = model_dec(i_addr);
        e.err  = md[4];
        e.dec  = md[3:0];
        e.addr = i_addr;
        e.data = i_data;
        sb.push_back(e);
      end
      if (i_rsp_valid && m_pend == 0) m_fault = 1'b1;
      m_pend = m_pend + ((o_valid && !i_stall) ? 1 : 0) - ((i_rsp_valid && m_pend > 0) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input int budget);
    int waited = 0;
    i_valid = 1'b1;
    i_addr  = a;
    i_data  = d;
    @(negedge i_clk);
    while (o_stall && waited < budget) begin
      @(negedge i_clk);
      waited++;
    end
    if (o_stall) check("send_timeout", 64'(waited), 64'(budget + 1));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic respond(input int n);
    i_rsp_valid = 1'b1;
    tick(n);
    i_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_decode", {60'd0, o_decode}, 64'd0);
    check("rst_addr", {32'd0, o_addr}, 64'd0);
    check("rst_data", {32'd0, o_data}, 64'd0);
    check("rst_err", {63'd0, o_err}, 64'd0);
    check("rst_pending", {62'd0, o_pending}, 64'd0);
    check("rst_fault", {63'd0, o_fault}, 64'd0);
    i_reset_n = 1'b1;
    tick(1);

    // single mapped request to slave 2
    send(32'h4000_0010, 32'h0000_00A5, 4);
    check("single_valid", {63'd0, o_valid}, 64'd1);
    check("single_dec", {60'd0, o_decode}, 64'h4);
    tick(1);
    check("single_pend", {62'd0, o_pending}, 64'd1);
    respond(1);
    check("single_drain", {62'd0, o_pending}, 64'd0);

    // ordering lock: two to slave 1, then slave 3 must wait
    send(32'h8000_0004, 32'h1111_0001, 4);
    send(32'h8000_0008, 32'h1111_0002, 4);
    i_valid = 1'b1; i_addr = 32'hC000_0000; i_data = 32'h3333_0003;
    @(negedge i_clk);
    check("lock_stall0", {63'd0, o_stall}, 64'd1);
    tick(1);
    i_rsp_valid = 1'b1;
    @(negedge i_clk);
    check("lock_stall1", {63'd0, o_stall}, 64'd1);
    tick(1);
    @(negedge i_clk);
    check("lock_stall2", {63'd0, o_stall}, 64'd1);
    tick(1);
    i_rsp_valid = 1'b0;
    @(negedge i_clk);
    check("lock_release", {63'd0, o_stall}, 64'd0);
    tick(1);
    i_valid = 1'b0;
    check("lock_dec", {60'd0, o_decode}, 64'h8);
    tick(1);
    respond(1);

    // credit limit: MAXPEND = 3
    send(32'h0000_1000, 32'hC0DE_0001, 4);
    send(32'h0000_1004, 32'hC0DE_0002, 4);
    send(32'h0000_1008, 32'hC0DE_0003, 4);
    i_valid = 1'b1; i_addr = 32'h0000_100C; i_data = 32'hC0DE_0004;
    @(negedge i_clk);
    check("credit_stall0", {63'd0, o_stall}, 64'd1);
    tick(1);
    @(negedge i_clk);
    check("credit_full", {62'd0, o_pending}, 64'd3);
    check("credit_stall1", {63'd0, o_stall}, 64'd1);
    tick(1);
    i_rsp_valid = 1'b1;
    @(negedge i_clk);
    check("credit_free", {63'd0, o_stall}, 64'd0);
    tick(1);
    i_valid = 1'b0;
    check("credit_after", {62'd0, o_pending}, 64'd2);
    tick(1);
    i_rsp_valid = 1'b0;
    check("issue_rsp_hold", {62'd0, o_pending}, 64'd2);
    respond(2);
    check("credit_drain", {62'd0, o_pending}, 64'd0);

    // unmapped request waits for a drained block, then errors
    send(32'h0000_0300, 32'h0000_0033, 4);
    i_valid = 1'b1; i_addr = 32'hF000_0000; i_data = 32'hDEAD_BEEF;
    @(negedge i_clk);
    check("unmap_busy", {63'd0, o_stall}, 64'd1);
    tick(1);
    i_rsp_valid = 1'b1;
    tick(1);
    i_rsp_valid = 1'b0;
    @(negedge i_clk);
    check("unmap_idle", {63'd0, o_stall}, 64'd0);
    tick(1);
    check("unmap_err", {63'd0, o_err}, 64'd1);
    check("unmap_novalid", {63'd0, o_valid}, 64'd0);
    i_addr = 32'h0000_0400; i_data = 32'h0000_0044;
    @(negedge i_clk);
    check("err_stall", {63'd0, o_stall}, 64'd1);
    tick(1);
    check("err_one_cycle", {63'd0, o_err}, 64'd0);
    @(negedge i_clk);
    check("err_release", {63'd0, o_stall}, 64'd0);
    tick(1);
    i_valid = 1'b0;
    check("err_next_valid", {63'd0, o_valid}, 64'd1);
    tick(1);
    respond(1);

    // backpressure holds the output register
    i_stall = 1'b1;
    send(32'h0000_0500, 32'h0000_0055, 4);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid", {63'd0, o_valid}, 64'd1);
      check("bp_addr", {32'd0, o_addr}, 64'h500);
      check("bp_data", {32'd0, o_data}, 64'h55);
      check("bp_dec", {60'd0, o_decode}, 64'h1);
    end
    i_stall = 1'b0;
    tick(1);
    respond(1);

    // response with nothing pending
    respond(1);
    check("fault_set", {63'd0, o_fault}, 64'd1);
    check("fault_pend", {62'd0, o_pending}, 64'd0);

    // reset mid-burst
    send(32'h0000_0600, 32'h0000_0066, 4);
    send(32'h0000_0700, 32'h0000_0077, 4);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
    check("mid_rst_decode", {60'd0, o_decode}, 64'd0);
    check("mid_rst_addr", {32'd0, o_addr}, 64'd0);
    check("mid_rst_data", {32'd0, o_data}, 64'd0);
    check("mid_rst_pend", {62'd0, o_pending}, 64'd0);
    check("mid_rst_fault", {63'd0, o_fault}, 64'd0);
    tick(2);
    i_reset_n = 1'b1;
    tick(1);
    respond(1);
    check("post_rst_fault", {63'd0, o_fault}, 64'd1);
    check("post_rst_pend", {62'd0, o_pending}, 64'd0);

    tick(2);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
